// File: rtl/save_ch2_arbiter_pkg.sv
// Shared types and constants for the SDRAM channel-2 save arbiter.
// Holds the FSM states, the requester IDs and the save-RAM address mapping.
package save_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_SS = 2'd0,
    REQ_LD = 2'd1,
    REQ_UL = 2'd2
  } req_id_e;

  localparam logic [6:0] SAVE_BASE_DEFAULT = 7'b0001111;

  // Save-RAM offsets live in a fixed 256 KiB window of SDRAM.
  function automatic logic [24:0] save_addr(input logic [6:0] base, input logic [17:0] offset);
    return {base, offset};
  endfunction

endpackage

// File: rtl/save_ch2_arbiter_if.sv
// SDRAM channel-2 request bus between the save arbiter and the sdram controller.
// The master side issues single-cycle rd/wr pulses; the slave side returns data and busy.
interface save_ch2_arbiter_if;
  logic [24:0] ch2_addr;
  logic        ch2_rd;
  logic        ch2_wr;
  logic [7:0]  ch2_din;
  logic [7:0]  ch2_dout;
  logic        ch2_busy;

  modport master (
    output ch2_addr, ch2_rd, ch2_wr, ch2_din,
    input  ch2_dout, ch2_busy
  );

  modport slave (
    input  ch2_addr, ch2_rd, ch2_wr, ch2_din,
    output ch2_dout, ch2_busy
  );
endinterface

// File: rtl/save_ch2_arbiter.sv
// Shares SDRAM channel 2 between the savestate engine, the save-RAM loader and unloader.
// Fixed priority savestate > loader > unloader, one transaction at a time, with busy watchdog.
module save_ch2_arbiter
  import save_arb_pkg::*;
#(
  parameter logic [6:0]  SAVE_BASE = SAVE_BASE_DEFAULT,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sleep_savestate,
  input  logic [24:0] ss_addr,
  input  logic        ss_rd,
  input  logic        ss_wr,
  input  logic [7:0]  ss_wdata,
  output logic [7:0]  ss_rdata,
  output logic        ss_done,
  input  logic        ld_req,
  input  logic [17:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  output logic        ld_ack,
  input  logic        ul_req,
  input  logic [17:0] ul_addr,
  output logic [7:0]  ul_rdata,
  output logic        ul_ack,
  save_ch2_arbiter_if.master ch2,
  output logic        save_busy,
  output logic        timeout_err,
  output logic        ss_overrun
);

  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  arb_state_e  r_state;
  req_id_e     r_gnt;
  logic        r_op_wr;
  logic [7:0]  r_cnt;

  logic        r_ss_pend;
  logic        r_ss_pend_wr;
  logic [24:0] r_ss_pend_addr;
  logic [7:0]  r_ss_pend_data;

  logic [24:0] r_ch2_addr;
  logic [7:0]  r_ch2_din;
  logic        r_ch2_rd;
  logic        r_ch2_wr;
  logic [7:0]  r_ss_rdata;
  logic        r_ss_done;
  logic        r_ld_ack;
  logic [7:0]  r_ul_rdata;
  logic        r_ul_ack;
  logic        r_timeout_err;
  logic        r_ss_overrun;

  logic        w_ss_pulse;
  logic        w_ss_clear;
  logic        w_finish;
  logic [7:0]  w_rdata;
  logic        w_gnt_valid;
  req_id_e     w_gnt_id;
  logic        w_gnt_wr;
  logic [24:0] w_gnt_addr;
  logic [7:0]  w_gnt_data;

  assign w_ss_pulse = ss_rd | ss_wr;
  assign w_ss_clear = (r_state == ST_DONE) && (r_gnt == REQ_SS);
  assign w_finish   = (r_state == ST_WAIT) && (!ch2.ch2_busy || (r_cnt == TIMEOUT_LAST));
  assign w_rdata    = ch2.ch2_busy ? 8'hFF : ch2.ch2_dout;

  // Grant selection evaluated in IDLE: pending savestate first, sleep masks ld/ul.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_id    = REQ_SS;
    w_gnt_wr    = 1'b0;
    w_gnt_addr  = 25'd0;
    w_gnt_data  = 8'd0;
    if (r_ss_pend) begin
      w_gnt_valid = 1'b1;
      w_gnt_id    = REQ_SS;
      w_gnt_wr    = r_ss_pend_wr;
      w_gnt_addr  = r_ss_pend_addr;
      w_gnt_data  = r_ss_pend_data;
    end else if (!sleep_savestate && ld_req) begin
      w_gnt_valid = 1'b1;
      w_gnt_id    = REQ_LD;
      w_gnt_wr    = 1'b1;
      w_gnt_addr  = save_addr(SAVE_BASE, ld_addr);
      w_gnt_data  = ld_wdata;
    end else if (!sleep_savestate && ul_req) begin
      w_gnt_valid = 1'b1;
      w_gnt_id    = REQ_UL;
      w_gnt_wr    = 1'b0;
      w_gnt_addr  = save_addr(SAVE_BASE, ul_addr);
      w_gnt_data  = 8'd0;
    end else begin
      w_gnt_valid = 1'b0;
    end
  end

  // Savestate pulse capture; the slot frees in DONE, so a pulse then is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ss_pend      <= 1'b0;
      r_ss_pend_wr   <= 1'b0;
      r_ss_pend_addr <= 25'd0;
      r_ss_pend_data <= 8'd0;
      r_ss_overrun   <= 1'b0;
    end else if (w_ss_pulse) begin
      if (r_ss_pend && !w_ss_clear) begin
        r_ss_overrun <= 1'b1;
      end else begin
        r_ss_pend      <= 1'b1;
        r_ss_pend_wr   <= ss_wr;
        r_ss_pend_addr <= ss_addr;
        r_ss_pend_data <= ss_wdata;
      end
    end else if (w_ss_clear) begin
      r_ss_pend <= 1'b0;
    end
  end

  // Transaction FSM; one counter serves both the settle delay and the WAIT watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_gnt         <= REQ_SS;
      r_op_wr       <= 1'b0;
      r_cnt         <= 8'd0;
      r_ch2_addr    <= 25'd0;
      r_ch2_din     <= 8'd0;
      r_ch2_rd      <= 1'b0;
      r_ch2_wr      <= 1'b0;
      r_ss_rdata    <= 8'd0;
      r_ss_done     <= 1'b0;
      r_ld_ack      <= 1'b0;
      r_ul_rdata    <= 8'd0;
      r_ul_ack      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ch2_rd  <= 1'b0;
      r_ch2_wr  <= 1'b0;
      r_ss_done <= 1'b0;
      r_ld_ack  <= 1'b0;
      r_ul_ack  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_state    <= ST_ISSUE;
            r_gnt      <= w_gnt_id;
            r_op_wr    <= w_gnt_wr;
            r_ch2_addr <= w_gnt_addr;
            r_ch2_din  <= w_gnt_data;
            r_ch2_wr   <= w_gnt_wr;
            r_ch2_rd   <= !w_gnt_wr;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_SETTLE;
          r_cnt   <= 8'd0;
        end
        ST_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_state <= ST_WAIT;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_WAIT: begin
          if (w_finish) begin
            r_state <= ST_DONE;
            if (ch2.ch2_busy) begin
              r_timeout_err <= 1'b1;
            end
            case (r_gnt)
              REQ_SS: begin
                r_ss_done <= 1'b1;
                if (!r_op_wr) begin
                  r_ss_rdata <= w_rdata;
                end
              end
              REQ_LD: r_ld_ack <= 1'b1;
              REQ_UL: begin
                r_ul_ack   <= 1'b1;
                r_ul_rdata <= w_rdata;
              end
              default: r_state <= ST_DONE;
            endcase
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ch2.ch2_addr = r_ch2_addr;
  assign ch2.ch2_din  = r_ch2_din;
  assign ch2.ch2_rd   = r_ch2_rd;
  assign ch2.ch2_wr   = r_ch2_wr;
  assign ss_rdata     = r_ss_rdata;
  assign ss_done      = r_ss_done;
  assign ld_ack       = r_ld_ack;
  assign ul_rdata     = r_ul_rdata;
  assign ul_ack       = r_ul_ack;
  assign timeout_err  = r_timeout_err;
  assign ss_overrun   = r_ss_overrun;
  assign save_busy    = (r_state != ST_IDLE) || r_ss_pend;

endmodule

// File: doc/save_ch2_arbiter.md
# save_ch2_arbiter

Sequences and shares SDRAM channel 2 between three requesters: the savestate engine, the save-RAM loader (APF bridge to SDRAM), and the save-RAM unloader (SDRAM to APF bridge). It sits between those requesters and the `sdram` controller's `ch2_*` port. It converts level req/ack and pulse-style requests into single `ch2_rd`/`ch2_wr` pulses, enforces savestate priority under `sleep_savestate`, and guards against a stuck `ch2_busy` with a watchdog.

## Interface
Parameters:
- `SAVE_BASE`, default 7'b0001111: upper 7 address bits prepended to 18-bit save-RAM offsets.
- `SETTLE`, default 2: cycles after a pulse during which `ch2_busy` is ignored (range 1–15).
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before abort (8-bit).

Ports:
- `clk`  in  1  system clock; all logic in this single domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sleep_savestate`  in  1  when high, only the savestate port may be granted.
- `ss_addr`  in  25  savestate byte address.
- `ss_rd` / `ss_wr`  in  1  one-cycle request pulses.
- `ss_wdata`  in  8  savestate write data.
- `ss_rdata`  out  8  savestate read data.
- `ss_done`  out  1  one-cycle completion pulse.
- `ld_req`  in  1  level write request from the loader.
- `ld_addr`  in  18  loader offset.
- `ld_wdata`  in  8  loader write data.
- `ld_ack`  out  1  one-cycle acknowledge.
- `ul_req`  in  1  level read request from the unloader.
- `ul_addr`  in  18  unloader offset.
- `ul_rdata`  out  8  unloader read data.
- `ul_ack`  out  1  one-cycle acknowledge.
- `ch2_addr`  out  25  channel address.
- `ch2_rd` / `ch2_wr`  out  1  one-cycle pulses to `sdram`.
- `ch2_din`  out  8  channel write data.
- `ch2_dout`  in  8  channel read data.
- `ch2_busy`  in  1  channel busy.
- `save_busy`  out  1  high when the FSM is not IDLE or a savestate request is pending.
- `timeout_err`  out  1  sticky watchdog flag.
- `ss_overrun`  out  1  sticky flag: a savestate pulse was dropped.

## Operation
- `ss_rd`/`ss_wr` pulses are captured into a pending register (op, address, data) in any state.
  - A pulse arriving while a savestate request is already pending is dropped and sets `ss_overrun`.
  - If `ss_rd` and `ss_wr` arrive in the same cycle, the write wins.
- Grant priority is fixed: pending savestate > `ld_req` > `ul_req`.
  - With `sleep_savestate` high, only savestate is eligible.
  - A pending savestate request is served regardless of `sleep_savestate`.
- Address mapping:
  - Savestate uses `ss_addr` directly.
  - `ld`/`ul` use {`SAVE_BASE`, offset}.
- FSM states:
  - IDLE: evaluate grant. If a winner exists, latch address, data, op and requester ID, then go to ISSUE.
  - ISSUE: `ch2_rd` or `ch2_wr` high for exactly this cycle; go to SETTLE.
  - SETTLE: count `SETTLE` cycles while ignoring `ch2_busy`; go to WAIT.
  - WAIT: when `ch2_busy` is low, capture `ch2_dout` (reads) and go to DONE. The watchdog increments each WAIT cycle; on reaching `TIMEOUT`, set `timeout_err` and go to DONE with read data = 8'hFF.
  - DONE: pulse the granted requester's `ack`/`done` for one cycle with read data valid; clear savestate pending if that was the grant; go to IDLE.
- `ch2_addr`/`ch2_din` are registered and hold their values from ISSUE until the next grant.
- A `sleep_savestate` change mid-transaction does not abort; it takes effect at the next IDLE evaluation.
- Read data outputs hold until the next completion on the same port.

## Timing
- Reset values:
  - All outputs 0, FSM in IDLE.
  - Pending request, watchdog and sticky flags cleared.
  - Reset mid-transaction drops the transaction with no ack/done.
- Latency with `SETTLE`=2 and `ch2_busy` never high:
  - Request visible in IDLE at cycle 0.
  - Pulse at cycle 1, SETTLE at cycles 2–3, WAIT at cycle 4, ack at cycle 5, IDLE at cycle 6.
  - General latency to ack = `SETTLE` + 3 + (cycles `ch2_busy` is high after SETTLE).
- Savestate pulse capture adds 1 cycle: a pulse at cycle −1 is pending at cycle 0.
- Requesters deassert `req` by the clock edge following `ack`. A `req` still high in IDLE is a new request.
- Back-to-back transactions are 6 cycles apart minimum (`SETTLE`=2).

## Structure
- Package `save_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, SETTLE, WAIT, DONE);
  - the requester ID enum (REQ_SS, REQ_LD, REQ_UL);
  - the default `SAVE_BASE` constant.
- Single flat module; no sub-module is warranted. The watchdog and settle counters share one 8-bit counter.

## Test plan
- `ld_req` with offset 18'h00010, data 8'hA5, `ch2_busy` low → `ch2_wr` pulse at cycle 1, `ch2_addr`=25'h03C0010, `ld_ack` at cycle 5.
- `ul_req` with offset 18'h00003; `ch2_busy` high cycles 2–7, `ch2_dout`=8'h3C → `ul_ack` at cycle 9 with `ul_rdata`=8'h3C.
- `ld_req` and `ul_req` held while an `ss_wr` pulse arrives → savestate granted first, then `ld`, then `ul`, in that order.
- `sleep_savestate` high with `ld_req` held and no savestate pending → no grant and `save_busy` low. Drop `sleep_savestate` → `ld` served.
- `ch2_busy` stuck high → after 255 WAIT cycles the ack fires, `timeout_err`=1, read data 8'hFF. Second `ss_rd` pulse while the first is pending → `ss_overrun`=1 and only one `ss_done`.
- Deassert `reset_n` during WAIT → outputs 0 immediately, no ack. After release, a new `ld_req` completes normally.
